scan_buffer_tx: RTL and testbench
=================================

// Module: scan_buffer_tx
// PURPOSE
//  Parametrised scanner. Samples a narrow input at a divided rate into a DEPTH-entry buffer.
//  Holds the buffer when full, then streams it out as a framed serial word with a generated bit clock.
//  Sits between local sensor/switch inputs and the inter-board serial link; successor of the fixed 2x2-bit scanner.
// PARAMETERS
//  DATA_W      2   bits per sample (sample_in width)
//  DEPTH       2   samples per frame (buffer entries); >=1
//  SAMPLE_DIV  8   clk cycles between samples while scanning; >=2
//  BIT_DIV     1   clk cycles per clk_out phase; one bit lasts 2*BIT_DIV cycles; >=1
// PORTS
//  clk                 in   1                  system clock; all logic on posedge
//  rst                 in   1                  synchronous, active-high reset
//  scan_start          in   1                  level; starts a scan when ps==IDLE
//  sample_in           in   DATA_W             local data, captured only on sample strobe
//  ready_for_transfer  in   1                  level; remote side ready to receive
//  clk_out             out  1                  serial bit clock; receiver samples on its rising edge
//  data_out            out  1                  serial data
//  frame_out           out  1                  high for the whole transfer
//  ps                  out  2                  state: 00 IDLE, 01 SCAN, 10 FULL, 11 XFER
//  buf_count           out  $clog2(DEPTH+1)    samples currently buffered
// BEHAVIOUR
//  Reset: ps=IDLE; clk_out, data_out, frame_out = 0; buf_count = 0.
//    Sample counter and bit counters are zeroed. Buffer contents are don't-care.
//  Reset mid-operation aborts the scan or transfer at that edge; no partial frame is resumed.
//  IDLE: scan_start=1 -> SCAN next edge, sample counter 0. All other inputs are ignored.
//  SCAN: sample counter counts 0..SAMPLE_DIV-1 and wraps.
//    At count==SAMPLE_DIV-1: buf[buf_count] <= sample_in; buf_count++.
//    First capture occurs SAMPLE_DIV cycles after SCAN entry.
//    If the capture makes buf_count==DEPTH: -> FULL on that same edge.
//  FULL: buffer frozen. ready_for_transfer=1 sampled -> XFER next edge.
//    If ready_for_transfer is already high on FULL entry, still waits one FULL cycle.
//  XFER: frame_out=1. First bit is valid on data_out in the first XFER cycle.
//    Bit order: buf[0] first; within each entry, MSB first.
//    Each bit: clk_out low for BIT_DIV cycles, then high for BIT_DIV cycles.
//    data_out changes only at the start of the low phase.
//    After the high phase of the last bit: -> IDLE; clk_out=0, frame_out=0, data_out=0, buf_count=0.
//  Outside XFER: clk_out=0, data_out=0, frame_out=0.
//  ready_for_transfer dropping mid-XFER is ignored; the frame completes.
//  scan_start outside IDLE is ignored. A scan_start held high restarts a scan from IDLE
//    one cycle after the frame ends.
//  Frame length: NBITS = DEPTH*DATA_W (+1 with parity); XFER duration = NBITS*2*BIT_DIV cycles.
//  Counter widths: $clog2 of each range, minimum 1 bit. No counter may overflow at any legal parameter value.
// CONFIGURATION
//  SCAN_PARITY_EN defined: one even-parity bit (XOR of all payload bits) is sent after the last data bit.
//    It has the same timing as a data bit.
//  SCAN_PARITY_EN undefined: no parity bit; frame is payload only.
// STRUCTURE
//  Package scan_pkg: state localparams (S_IDLE/S_SCAN/S_FULL/S_XFER), state width,
//    and a clog2-min-1 width helper function.
//  Sub-module scan_bit_clk: BIT_DIV phase counter; outputs clk_out and a bit_done pulse.
//    Enabled only in XFER; cleared by rst or !en.
//  Top level holds the FSM, sample counter, buffer and bit index.
// TESTING  (defaults unless stated)
//  1 rst=1 for 2 cycles with random inputs -> ps=00, buf_count=0, clk_out=data_out=frame_out=0.
//  2 sample_in=01, scan_start pulse -> ps=01 next edge.
//    Captures at SCAN cycles 8 and 16; ps=10 and buf_count=2 after the 16th edge.
//  3 from test 2, ready_for_transfer=1 -> data_out sequence 0,1,0,1, each bit lasting 2 cycles.
//    clk_out pattern 0,1 per bit; frame_out high for 8 cycles; then ps=00.
//  4 samples 01 then 11 with SCAN_PARITY_EN -> bits 0,1,1,1 then parity 1; frame_out high for 10 cycles.
//    Without the macro -> 8 cycles, no parity bit.
//  5 rst pulsed mid-XFER (after bit 2) -> outputs at reset values next edge.
//    A new scan_start then produces a full, correct frame.
//  6 DEPTH=4, DATA_W=3, BIT_DIV=2, ready_for_transfer dropped mid-frame
//    -> all 12 bits sent, MSB-first per entry, each bit lasting 4 cycles; XFER lasts 48 cycles.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan buffer transmitter: state encoding and width helper.
package scan_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'b00,
      S_SCAN = 2'b01,
      S_FULL = 2'b10,
      S_XFER = 2'b11
   } scanState_t;

   // Bits needed to hold 0..v-1, never less than one.
   function automatic int clogMin1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/scan_bit_clk.sv
// Serial bit clock: BIT_DIV cycles low, BIT_DIV cycles high; bit_done marks the last high cycle.
module scan_bit_clk
   import scan_pkg::*;
#(
   parameter int BIT_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic clk_out,
   output logic bit_done
);

   localparam int PW = clogMin1(BIT_DIV);
   localparam logic [PW-1:0] PH_LAST = PW'(BIT_DIV - 1);

   logic [PW-1:0] phaseCnt;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         phaseCnt <= '0;
         clk_out  <= 1'b0;
      end else if (phaseCnt == PH_LAST) begin
         phaseCnt <= '0;
         clk_out  <= ~clk_out;
      end else begin
         phaseCnt <= phaseCnt + PW'(1);
      end
   end

   assign bit_done = en && clk_out && (phaseCnt == PH_LAST);

endmodule

// File: rtl/scan_buffer_tx.sv
// Samples sample_in into a DEPTH-entry buffer, then sends it as a framed serial word.
// Define SCAN_PARITY_EN to append an even-parity bit after the payload.
module scan_buffer_tx
   import scan_pkg::*;
#(
   parameter int DATA_W     = 2,
   parameter int DEPTH      = 2,
   parameter int SAMPLE_DIV = 8,
   parameter int BIT_DIV    = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         scan_start,
   input  logic [DATA_W-1:0]            sample_in,
   input  logic                         ready_for_transfer,
   output logic                         clk_out,
   output logic                         data_out,
   output logic                         frame_out,
   output logic [STATE_W-1:0]           ps,
   output logic [clogMin1(DEPTH+1)-1:0] buf_count
);

   localparam int PAY_W = DATA_W * DEPTH;
`ifdef SCAN_PARITY_EN
   localparam int NBITS = PAY_W + 1;
`else
   localparam int NBITS = PAY_W;
`endif
   localparam int SCW = clogMin1(SAMPLE_DIV);
   localparam int BIW = clogMin1(NBITS);
   localparam int BCW = clogMin1(DEPTH + 1);
   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_DIV - 1);
   localparam logic [BIW-1:0] BIT_LAST    = BIW'(NBITS - 1);
   localparam logic [BCW-1:0] FILL_LAST   = BCW'(DEPTH - 1);

   scanState_t                     state;
   logic [SCW-1:0]                 sampleCnt;
   logic [BCW-1:0]                 bufCount;
   logic [BIW-1:0]                 bitIdx;
   logic [DEPTH-1:0][DATA_W-1:0]   bufMem;
   logic [NBITS-1:0]               frameBits;
   logic                           capture;
   logic                           bitDone;

   assign capture   = (state == S_SCAN) && (sampleCnt == SAMPLE_LAST);
   assign ps        = state;
   assign buf_count = bufCount;

   // Transmit order lives at frameBits[0] upward: entry 0 first, MSB first within an entry.
   always_comb begin
      frameBits = '0;
      for (int e = 0; e < DEPTH; e++)
         for (int b = 0; b < DATA_W; b++)
            frameBits[e*DATA_W + DATA_W-1-b] = bufMem[e][b];
`ifdef SCAN_PARITY_EN
      frameBits[NBITS-1] = ^bufMem;
`endif
   end

   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++)
         if (capture && bufCount == BCW'(e))
            bufMem[e] <= sample_in;
   end

   scan_bit_clk #(.BIT_DIV(BIT_DIV)) uBitClk (
      .clk      (clk),
      .rst      (rst),
      .en       (state == S_XFER),
      .clk_out  (clk_out),
      .bit_done (bitDone)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         sampleCnt <= '0;
         bufCount  <= '0;
         bitIdx    <= '0;
         data_out  <= 1'b0;
         frame_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (scan_start) begin
               state     <= S_SCAN;
               sampleCnt <= '0;
               bufCount  <= '0;
            end
            S_SCAN: if (capture) begin
               sampleCnt <= '0;
               bufCount  <= bufCount + BCW'(1);
               if (bufCount == FILL_LAST) state <= S_FULL;
            end else begin
               sampleCnt <= sampleCnt + SCW'(1);
            end
            S_FULL: if (ready_for_transfer) begin
               state     <= S_XFER;
               bitIdx    <= '0;
               frame_out <= 1'b1;
               data_out  <= frameBits[0];
            end
            S_XFER: if (bitDone) begin
               if (bitIdx == BIT_LAST) begin
                  state     <= S_IDLE;
                  bitIdx    <= '0;
                  bufCount  <= '0;
                  frame_out <= 1'b0;
                  data_out  <= 1'b0;
               end else begin
                  bitIdx   <= bitIdx + BIW'(1);
                  data_out <= frameBits[bitIdx + BIW'(1)];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_buffer_tx.sv
// Scoreboard bench: stimulus queues expected bits and frame lengths, a monitor checks each bit clock rise.
module tb_scan_buffer_tx;

`ifdef SCAN_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // default instance
   logic       start0 = 0, ready0 = 0;
   logic [1:0] samp0 = '0;
   logic       co0, do0, fo0;
   logic [1:0] ps0, bc0;

   // wide instance: DEPTH=4, DATA_W=3, BIT_DIV=2
   logic       start1 = 0, ready1 = 0;
   logic [2:0] samp1 = '0;
   logic       co1, do1, fo1;
   logic [1:0] ps1;
   logic [2:0] bc1;

   scan_buffer_tx u0 (
      .clk(clk), .rst(rst), .scan_start(start0), .sample_in(samp0),
      .ready_for_transfer(ready0), .clk_out(co0), .data_out(do0),
      .frame_out(fo0), .ps(ps0), .buf_count(bc0));

   scan_buffer_tx #(.DATA_W(3), .DEPTH(4), .SAMPLE_DIV(4), .BIT_DIV(2)) u1 (
      .clk(clk), .rst(rst), .scan_start(start1), .sample_in(samp1),
      .ready_for_transfer(ready1), .clk_out(co1), .data_out(do1),
      .frame_out(fo1), .ps(ps1), .buf_count(bc1));

   int nCmp = 0, nErr = 0;
   bit bitQ[2][$];
   int lenQ[2][$];
   int fc[2];
   int bitN[2];
   logic prevClk[2] = '{1'b0, 1'b0};
   logic prevFrm[2] = '{1'b0, 1'b0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // bits[n-1] is sent first
   task automatic pushFrame(input int id, input logic [15:0] bits, input int n, input int bd);
      for (int i = n-1; i >= 0; i--) bitQ[id].push_back(bits[i]);
      if (PAR == 1) begin
         logic p;
         p = 1'b0;
         for (int i = 0; i < n; i++) p = p ^ bits[i];
         bitQ[id].push_back(p);
      end
      lenQ[id].push_back((n + PAR) * 2 * bd);
   endtask

   task automatic monStep(input int id, input logic co, input logic d, input logic fo, input int bd);
      if (fo) begin
         if (!prevFrm[id]) begin
            fc[id] = 1;
            bitN[id] = 0;
         end else fc[id]++;
         if (co && !prevClk[id]) begin
            if (bitQ[id].size() == 0) begin
               nCmp++; nErr++;
               $display("FAIL unexpected_bit[%0d]: got rise at cycle %0d expected none", id, fc[id]);
            end else begin
               chk($sformatf("bit%0d[%0d]", bitN[id], id), d, bitQ[id].pop_front());
               chk($sformatf("rise_time%0d[%0d]", bitN[id], id), fc[id], bitN[id]*2*bd + bd + 1);
            end
            bitN[id]++;
         end
      end else begin
         chk($sformatf("idle_lines[%0d]", id), {co, d}, 0);
         if (prevFrm[id]) begin
            if (lenQ[id].size() == 0) begin
               nCmp++; nErr++;
               $display("FAIL unexpected_frame[%0d]: got length %0d expected none", id, fc[id]);
            end else chk($sformatf("frame_len[%0d]", id), fc[id], lenQ[id].pop_front());
         end
      end
      prevClk[id] = co;
      prevFrm[id] = fo;
   endtask

   always @(posedge clk) begin
      #1;
      monStep(0, co0, do0, fo0, 1);
      monStep(1, co1, do1, fo1, 2);
   end

   task automatic waitIdle(input int id, input int maxc);
      int n;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (((id == 0) ? ps0 : ps1) != 2'b00 && n < maxc);
      chk($sformatf("reach_idle[%0d]", id), (id == 0) ? ps0 : ps1, 2'b00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with random inputs
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         start0 = 1'($urandom_range(0, 1)); ready0 = 1'($urandom_range(0, 1));
         samp0  = 2'($urandom_range(0, 3));
         start1 = 1'($urandom_range(0, 1)); ready1 = 1'($urandom_range(0, 1));
         cyc(1);
      end
      chk("rst_ps", ps0, 0);
      chk("rst_bc", bc0, 0);
      chk("rst_lines", {co0, do0, fo0}, 0);
      chk("rst_ps1", ps1, 0);
      start0 = 0; ready0 = 0; start1 = 0; ready1 = 0;
      rst = 0;
      cyc(1);

      // scan two samples of 01
      samp0 = 2'b01; start0 = 1;
      cyc(1);
      start0 = 0;
      chk("scan_entry", ps0, 2'b01);
      cyc(7);
      chk("pre_capture_bc", bc0, 0);
      cyc(1);
      chk("capture1_bc", bc0, 1);
      chk("capture1_ps", ps0, 2'b01);
      cyc(8);
      chk("full_ps", ps0, 2'b10);
      chk("full_bc", bc0, 2);

      // transfer 0,1,0,1
      pushFrame(0, 16'b0101, 4, 1);
      ready0 = 1;
      cyc(1);
      chk("xfer_ps", ps0, 2'b11);
      chk("xfer_first", {fo0, do0, co0}, 3'b100);
      waitIdle(0, 40);
      chk("end_bc", bc0, 0);
      ready0 = 0;

      // samples 01 then 11
      samp0 = 2'b01; start0 = 1;
      cyc(1);
      start0 = 0;
      cyc(8);
      samp0 = 2'b11;
      cyc(8);
      chk("full2_ps", ps0, 2'b10);
      pushFrame(0, 16'b0111, 4, 1);
      ready0 = 1;
      waitIdle(0, 40);
      ready0 = 0;

      // reset mid-transfer
      samp0 = 2'b10; start0 = 1;
      cyc(1);
      start0 = 0;
      cyc(16);
      chk("full3_ps", ps0, 2'b10);
      bitQ[0].push_back(1'b1);
      bitQ[0].push_back(1'b0);
      lenQ[0].push_back(5);
      ready0 = 1;
      cyc(1);
      ready0 = 0;
      cyc(4);
      rst = 1;
      cyc(1);
      chk("abort_ps", ps0, 0);
      chk("abort_lines", {co0, do0, fo0}, 0);
      chk("abort_bc", bc0, 0);
      rst = 0;

      // fresh frame 11,00 with scan_start held through the end
      samp0 = 2'b11; start0 = 1;
      cyc(1);
      chk("rescan_ps", ps0, 2'b01);
      cyc(8);
      samp0 = 2'b00;
      cyc(8);
      chk("full4_ps", ps0, 2'b10);
      pushFrame(0, 16'b1100, 4, 1);
      ready0 = 1;
      waitIdle(0, 40);
      ready0 = 0;
      cyc(1);
      chk("held_restart_ps", ps0, 2'b01);
      start0 = 0;
      rst = 1;
      cyc(1);
      rst = 0;

      // wide instance: 101,011,110,001 with ready dropped mid-frame
      samp1 = 3'b101; start1 = 1;
      cyc(1);
      start1 = 0;
      cyc(4); samp1 = 3'b011;
      cyc(4); samp1 = 3'b110;
      cyc(4); samp1 = 3'b001;
      cyc(4);
      chk("w_full_ps", ps1, 2'b10);
      chk("w_full_bc", bc1, 4);
      pushFrame(1, 16'b101011110001, 12, 2);
      ready1 = 1;
      cyc(1);
      chk("w_xfer_ps", ps1, 2'b11);
      cyc(10);
      ready1 = 0;
      waitIdle(1, 100);

      cyc(5);
      chk("q0_drained", bitQ[0].size() + lenQ[0].size(), 0);
      chk("q1_drained", bitQ[1].size() + lenQ[1].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
